// File: rtl/pattern_scorer_if.sv
// Bus between the game front end and pattern_scorer: game stimulus in, score state out.
// Handshake: game_tick and write are single-cycle strobes sampled on the rising clock edge,
// pattern/user_input are qualified only by their strobe, and outputs are registered levels (hit is a 1-cycle pulse).
interface pattern_scorer_if #(
  parameter int PAT_W   = 8,
  parameter int SCORE_W = 11
);
  logic               game_tick;
  logic [PAT_W-1:0]   pattern;
  logic               write;
  logic [PAT_W-1:0]   user_input;
  logic [SCORE_W-1:0] score_out;
  logic [PAT_W-1:0]   pattern_out;
  logic [3:0]         points_out;
  logic [2:0]         combo_out;
  logic [3:0]         miss_count;
  logic               game_over;
  logic               hit;
  logic [1:0]         state_dbg;

  modport master (
    output game_tick, pattern, write, user_input,
    input  score_out, pattern_out, points_out, combo_out, miss_count, game_over, hit, state_dbg
  );

  modport slave (
    input  game_tick, pattern, write, user_input,
    output score_out, pattern_out, points_out, combo_out, miss_count, game_over, hit, state_dbg
  );
endinterface

// File: rtl/pattern_scorer.sv
// Reaction-game scorer: a live pattern decays one point per tick; a matching write scores
// points*combo, mismatches and expiries count as misses until the game is over.
module pattern_scorer #(
  parameter int PAT_W      = 8,
  parameter int SCORE_W    = 11,
  parameter int MAX_PTS    = 10,
  parameter int COMBO_MAX  = 4,
  parameter int MISS_LIMIT = 3
) (
  input  logic          CLOCK50M,
  input  logic          reset,
  pattern_scorer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    OVER   = 2'd2
  } state_t;

  localparam int              SUM_W     = ((SCORE_W > 7) ? SCORE_W : 7) + 1;
  localparam logic [3:0]      PTS_LOAD  = 4'(MAX_PTS);
  localparam logic [2:0]      COMBO_TOP = 3'(COMBO_MAX);
  localparam logic [4:0]      MISS_TOP  = 5'(MISS_LIMIT);
  localparam logic [SUM_W-1:0] SCORE_TOP = {{(SUM_W-SCORE_W){1'b0}}, {SCORE_W{1'b1}}};

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [3:0]         pts_q, pts_d;
  logic [2:0]         combo_q, combo_d;
  logic [3:0]         miss_q, miss_d;
  logic               hit_q, hit_d;

  logic               match;
  logic               tick_new;
  logic [6:0]         product;
  logic [SUM_W-1:0]   sum;
  logic [1:0]         miss_inc;
  logic [4:0]         miss_sum;

  // Product is 7 bits wide so 15*7 never truncates, regardless of SCORE_W.
  assign match    = bus.write && (bus.user_input == pat_q);
  assign tick_new = bus.game_tick && (bus.pattern != '0);
  assign product  = {3'b000, pts_q} * {4'b0000, combo_q};
  assign sum      = SUM_W'(score_q) + SUM_W'(product);

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    pat_d    = pat_q;
    pts_d    = pts_q;
    combo_d  = combo_q;
    miss_d   = miss_q;
    hit_d    = 1'b0;
    miss_inc = 2'd0;
    miss_sum = {1'b0, miss_q};
    case (state_q)
      IDLE: begin
        if (tick_new) begin
          pat_d   = bus.pattern;
          pts_d   = PTS_LOAD;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (match) begin
          // The hit uses pre-tick points; a same-cycle tick then acts as if from IDLE.
          score_d = (sum > SCORE_TOP) ? SCORE_TOP[SCORE_W-1:0] : sum[SCORE_W-1:0];
          combo_d = (combo_q >= COMBO_TOP) ? COMBO_TOP : combo_q + 3'd1;
          hit_d   = 1'b1;
          if (tick_new) begin
            pat_d = bus.pattern;
            pts_d = PTS_LOAD;
          end else begin
            pat_d   = '0;
            pts_d   = 4'd0;
            state_d = IDLE;
          end
        end else begin
          if (bus.write) begin
            miss_inc = miss_inc + 2'd1;
            combo_d  = 3'd1;
          end
          if (bus.game_tick) begin
            if (tick_new) begin
              miss_inc = miss_inc + 2'd1;
              combo_d  = 3'd1;
              pat_d    = bus.pattern;
              pts_d    = PTS_LOAD;
            end else if (pts_q != 4'd0) begin
              pts_d = pts_q - 4'd1;
            end else begin
              miss_inc = miss_inc + 2'd1;
              combo_d  = 3'd1;
              pat_d    = '0;
              state_d  = IDLE;
            end
          end
          miss_sum = {1'b0, miss_q} + {3'b000, miss_inc};
          if (miss_sum >= MISS_TOP) begin
            miss_d  = MISS_TOP[3:0];
            pat_d   = '0;
            pts_d   = 4'd0;
            state_d = OVER;
          end else begin
            miss_d = miss_sum[3:0];
          end
        end
      end
      OVER: begin
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK50M) begin
    if (reset) begin
      state_q <= IDLE;
      score_q <= '0;
      pat_q   <= '0;
      pts_q   <= 4'd0;
      combo_q <= 3'd1;
      miss_q  <= 4'd0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      pat_q   <= pat_d;
      pts_q   <= pts_d;
      combo_q <= combo_d;
      miss_q  <= miss_d;
      hit_q   <= hit_d;
    end
  end

  assign bus.score_out   = score_q;
  assign bus.pattern_out = pat_q;
  assign bus.points_out  = pts_q;
  assign bus.combo_out   = combo_q;
  assign bus.miss_count  = miss_q;
  assign bus.game_over   = (state_q == OVER);
  assign bus.hit         = hit_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: doc/pattern_scorer.md
PATTERN_SCORER -- requirements
Module: pattern_scorer

Interface
REQ-001 SHALL have parameter PAT_W, default 8: width of pattern, user_input and pattern_out.
REQ-002 SHALL have parameter SCORE_W, default 11: width of score_out.
REQ-003 SHALL have parameter MAX_PTS, default 10: points loaded on a new pattern (1..15).
REQ-004 SHALL have parameter COMBO_MAX, default 4: ceiling of the combo multiplier (1..7).
REQ-005 SHALL have parameter MISS_LIMIT, default 3: misses that end the game (1..15).
REQ-006 SHALL have the following ports:
  - CLOCK50M  in   1        sole clock, all state updates on its rising edge.
  - reset  in   1        synchronous, active-high.
  - game_tick  in   1        one-cycle pulse synchronous to CLOCK50M, game step.
  - pattern  in   PAT_W    pattern offered at game_tick; 0 means no new pattern.
  - write  in   1        one-cycle strobe, user_input valid.
  - user_input  in   PAT_W    player answer.
  - score_out  out  SCORE_W  accumulated score.
  - pattern_out  out  PAT_W    live pattern, 0 when none.
  - points_out  out  4        points currently available.
  - combo_out  out  3        current multiplier.
  - miss_count  out  4        misses so far.
  - game_over  out  1        level, game ended.
  - hit  out  1        one-cycle pulse on a scoring write.

Function
REQ-007 SHALL implement states IDLE (no live pattern), ACTIVE (live pattern), OVER (game ended); pattern_out is nonzero only in ACTIVE.
REQ-008 IDLE, game_tick with pattern!=0: SHALL load pattern_out=pattern, points=MAX_PTS, go ACTIVE next cycle; pattern==0 or write alone: no change.
REQ-009 ACTIVE, write with user_input==pattern_out: SHALL add points*combo to score, saturate combo+1 at COMBO_MAX, pulse hit one cycle, clear pattern_out and points, go IDLE.
REQ-010 Score add SHALL saturate at 2^SCORE_W-1; product points*combo SHALL be computed without truncation before the add.
REQ-011 ACTIVE, write with mismatch: SHALL increment miss_count, reset combo to 1, keep pattern and points.
REQ-012 ACTIVE, game_tick with pattern!=0 and no hit: SHALL count the live pattern as a miss (miss_count+1, combo=1) and load the new pattern with points=MAX_PTS.
REQ-013 ACTIVE, game_tick with pattern==0: points>0 SHALL decrement points by 1; points==0 SHALL expire (miss_count+1, combo=1, clear pattern, go IDLE).
REQ-014 Same-cycle matching write and game_tick: hit SHALL be processed first using pre-tick points, then the tick SHALL be applied as from IDLE (REQ-008).
REQ-015 Same-cycle mismatching write and game_tick: both misses SHALL count (miss_count+2, saturating), then tick effect applied.
REQ-016 When miss_count reaches MISS_LIMIT, SHALL enter OVER the same edge: game_over=1, pattern_out=0, points=0; all inputs except reset ignored; score_out held.
REQ-017 miss_count SHALL saturate at MISS_LIMIT; combo SHALL never be below 1.

Reset
REQ-018 reset high at a rising edge SHALL, in any state including mid-ACTIVE, give next cycle: state IDLE, score_out=0, pattern_out=0, points_out=0, combo_out=1, miss_count=0, game_over=0, hit=0.
REQ-019 reset SHALL take priority over game_tick and write in the same cycle.

Verification
REQ-020 Bench SHALL cover, with default parameters:
  - Basic hit: tick pattern=0x5A, next cycle write 0x5A -> score_out=10, combo_out=2, hit one cycle, pattern_out=0.
  - Decay: tick 0x5A, three ticks pattern=0, then write 0x5A -> points_out=7 before write, score_out=7.
  - Combo: five immediate hits -> score_out 10, 30, 60, 100, 140; combo_out held at 4.
  - Expiry and game over: tick 0x01, 11 ticks pattern=0 -> points 10 to 0, 11th tick miss_count=1, pattern_out=0; two further mismatching writes on a new pattern -> game_over=1, later ticks ignored.
  - Simultaneous hit and new tick: live 0x5A, write 0x5A with tick pattern=0x3C -> score_out+=10, pattern_out=0x3C, points_out=10, hit pulse.
  - Saturation and reset: SCORE_W=6, repeated hits -> score_out stops at 63; reset asserted mid-ACTIVE -> all outputs at reset values next cycle.
